// File: rtl/icache_pkg.sv
// Shared types and sizing for the direct-mapped, one-word-per-frame instruction cache.
package icache_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icache_addr_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    function automatic word_t word_align(input word_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  flush;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single outstanding
// one-word fill on a miss, global invalidate on flush.
module icache
    import icache_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic     CLK,
    input  logic     RST,
    icache_if.slave  cif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]       state_r;
    word_t            miss_addr_r;
    logic [SETS-1:0]  valid_r;
    logic [TAG_W-1:0] tag_r  [SETS];
    word_t            data_r [SETS];

    logic [IDX_W-1:0] req_idx_s;
    logic [TAG_W-1:0] req_tag_s;
    logic [IDX_W-1:0] fill_idx_s;
    logic             hit_s;
    logic             fill_s;

    assign req_idx_s  = cif.imemaddr[IDX_W+1:2];
    assign req_tag_s  = cif.imemaddr[31:IDX_W+2];
    assign fill_idx_s = miss_addr_r[IDX_W+1:2];

    // Lookup: a hit is only possible while idle, and a fill only completes in FETCH.
    always_comb begin
        hit_s  = 1'b0;
        fill_s = 1'b0;
        if ((state_r == ST_IDLE) && cif.imemREN && valid_r[req_idx_s] &&
            (tag_r[req_idx_s] == req_tag_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if ((state_r == ST_FETCH) && !cif.iwait && !cif.flush && !RST) begin
            fill_s = 1'b1;
        end else begin
            fill_s = 1'b0;
        end
    end

    // Output drive; everything is held at zero while reset is asserted.
    always_comb begin
        cif.ihit     = 1'b0;
        cif.imemload = 32'h0000_0000;
        cif.iREN     = 1'b0;
        cif.iaddr    = 32'h0000_0000;
        if (RST) begin
            cif.ihit     = 1'b0;
            cif.imemload = 32'h0000_0000;
            cif.iREN     = 1'b0;
            cif.iaddr    = 32'h0000_0000;
        end else begin
            cif.ihit     = hit_s && !cif.flush;
            cif.imemload = valid_r[req_idx_s] ? data_r[req_idx_s] : 32'h0000_0000;
            cif.iREN     = (state_r == ST_FETCH);
            cif.iaddr    = (state_r == ST_FETCH) ? miss_addr_r : 32'h0000_0000;
        end
    end

    // Control state: FSM, miss address latch and valid bits; flush discards a pending fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            miss_addr_r <= 32'h0000_0000;
            valid_r     <= '0;
        end else if (cif.flush) begin
            state_r <= ST_IDLE;
            valid_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cif.imemREN && !hit_s) begin
                        state_r     <= ST_FETCH;
                        miss_addr_r <= word_align(cif.imemaddr);
                    end
                end
                ST_FETCH: begin
                    if (!cif.iwait) begin
                        valid_r[fill_idx_s] <= 1'b1;
                        state_r             <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; valid alone qualifies their contents.
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            tag_r[fill_idx_s]  <= miss_addr_r[31:IDX_W+2];
            data_r[fill_idx_s] <= cif.iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a word-address cache model predicts outputs every cycle,
// and hand-computed expectations pin the key points of each scenario.
module tb_icache;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    icache_if cif ();

    icache dut (
        .CLK (clk),
        .RST (rst),
        .cif (cif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: which word address each set holds, plus the one outstanding miss.
    logic        m_valid [16];
    logic [31:0] m_addr  [16];
    logic [31:0] m_data  [16];
    logic        m_pend;
    logic [31:0] m_paddr;
    logic        started;

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h0000_000F);
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return m_valid[set_of(a)] && (m_addr[set_of(a)] == (a & 32'hFFFF_FFFC));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        started = 1'b0;
        m_pend  = 1'b0;
        m_paddr = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = 32'h0;
            m_data[i]  = 32'h0;
        end
    end

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst || cif.flush) begin
            for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
            m_pend <= 1'b0;
        end else if (m_pend) begin
            if (!cif.iwait) begin
                m_valid[set_of(m_paddr)] <= 1'b1;
                m_addr[set_of(m_paddr)]  <= m_paddr;
                m_data[set_of(m_paddr)]  <= cif.iload;
                m_pend                   <= 1'b0;
            end
        end else if (cif.imemREN && !model_hit(cif.imemaddr)) begin
            m_pend  <= 1'b1;
            m_paddr <= cif.imemaddr & 32'hFFFF_FFFC;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        e_hit;
        logic        e_iren;
        if (started) begin
            e_hit  = !rst && !cif.flush && !m_pend && cif.imemREN && model_hit(cif.imemaddr);
            e_iren = !rst && m_pend;
            check("model_ihit", {31'b0, cif.ihit}, {31'b0, e_hit});
            check("model_iREN", {31'b0, cif.iREN}, {31'b0, e_iren});
            if (e_iren) check("model_iaddr", cif.iaddr, m_paddr);
            if (rst) begin
                check("model_rst_iaddr", cif.iaddr, 32'h0);
                check("model_rst_imemload", cif.imemload, 32'h0);
            end
            if (e_hit) check("model_imemload", cif.imemload, m_data[set_of(cif.imemaddr)]);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] d, input int waits);
        cif.imemREN  = 1'b1;
        cif.imemaddr = a;
        cif.iwait    = 1'b1;
        @(negedge clk);
        check("fill_miss", {31'b0, cif.ihit}, 32'd0);
        adv();
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            check("fill_iREN", {31'b0, cif.iREN}, 32'd1);
            check("fill_iaddr", cif.iaddr, a & 32'hFFFF_FFFC);
            check("fill_nohit", {31'b0, cif.ihit}, 32'd0);
            adv();
        end
        cif.iwait = 1'b0;
        cif.iload = d;
        adv();
        cif.iwait = 1'b1;
        cif.iload = 32'h0;
    endtask

    task automatic probe(input logic [31:0] a, input logic [31:0] d);
        cif.imemREN  = 1'b1;
        cif.imemaddr = a;
        @(negedge clk);
        check("probe_hit", {31'b0, cif.ihit}, 32'd1);
        check("probe_data", cif.imemload, d);
        check("probe_iREN", {31'b0, cif.iREN}, 32'd0);
        adv();
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        cif.imemREN  = 1'b0;
        cif.imemaddr = 32'h0;
        cif.flush    = 1'b0;
        cif.iwait    = 1'b1;
        cif.iload    = 32'h0;
        adv();
        @(negedge clk);
        check("reset_ihit", {31'b0, cif.ihit}, 32'd0);
        check("reset_iREN", {31'b0, cif.iREN}, 32'd0);
        check("reset_iaddr", cif.iaddr, 32'h0);
        adv();
        rst = 1'b0;

        // Cold miss: 3 busy cycles, fill on the 4th FETCH cycle, hit next cycle.
        fill(32'h0000_0104, 32'hDEAD_BEEF, 3);
        probe(32'h0000_0104, 32'hDEAD_BEEF);

        // Conflict eviction on set 0.
        fill(32'h0000_0000, 32'hAAAA_0000, 1);
        probe(32'h0000_0000, 32'hAAAA_0000);
        fill(32'h0000_0040, 32'hBBBB_0040, 2);
        probe(32'h0000_0040, 32'hBBBB_0040);
        fill(32'h0000_0000, 32'hAAAA_1111, 0);
        probe(32'h0000_0000, 32'hAAAA_1111);

        // Address change while FETCH is pending.
        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0000_0010;
        adv();
        cif.imemaddr = 32'h0000_0020;
        @(negedge clk);
        check("chg_iaddr_held", cif.iaddr, 32'h0000_0010);
        adv();
        cif.iwait = 1'b0;
        cif.iload = 32'hCCCC_0010;
        adv();
        cif.iwait = 1'b1;
        @(negedge clk);
        check("chg_new_miss", {31'b0, cif.ihit}, 32'd0);
        adv();
        @(negedge clk);
        check("chg_new_iaddr", cif.iaddr, 32'h0000_0020);
        adv();
        cif.iwait = 1'b0;
        cif.iload = 32'hDDDD_0020;
        adv();
        cif.iwait = 1'b1;
        probe(32'h0000_0020, 32'hDDDD_0020);
        probe(32'h0000_0010, 32'hCCCC_0010);

        // Flush in the same cycle as fill completion.
        cif.imemaddr = 32'h0000_0200;
        adv();
        cif.flush = 1'b1;
        cif.iwait = 1'b0;
        cif.iload = 32'h5555_5555;
        adv();
        cif.flush   = 1'b0;
        cif.iwait   = 1'b1;
        cif.imemREN = 1'b0;
        @(negedge clk);
        check("flush_idle_iREN", {31'b0, cif.iREN}, 32'd0);
        adv();
        fill(32'h0000_0104, 32'h0104_0104, 0);
        fill(32'h0000_0200, 32'h0200_0200, 0);
        probe(32'h0000_0200, 32'h0200_0200);

        // Flush forces ihit low on a would-be hit.
        cif.flush = 1'b1;
        @(negedge clk);
        check("flush_kills_hit", {31'b0, cif.ihit}, 32'd0);
        adv();
        cif.flush = 1'b0;

        // Reset during FETCH.
        cif.imemaddr = 32'h0000_0300;
        adv();
        adv();
        rst = 1'b1;
        adv();
        @(negedge clk);
        check("rst_mid_iREN", {31'b0, cif.iREN}, 32'd0);
        check("rst_mid_ihit", {31'b0, cif.ihit}, 32'd0);
        adv();
        rst = 1'b0;
        fill(32'h0000_0300, 32'h0300_0300, 1);
        probe(32'h0000_0300, 32'h0300_0300);

        // Long starvation with a non-aligned fetch address.
        fill(32'h0000_1236, 32'h1234_5678, 20);
        probe(32'h0000_1234, 32'h1234_5678);

        cif.imemREN = 1'b0;
        adv();
        adv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
